// File: rtl/uart_rx_io_if.sv
// CPU-side IO-page bus seen by the UART receiver: address/strobe/mask in, read data out.
interface uart_rx_io_if;
  logic [31:0] mem_addr;
  logic        mem_rstrb;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wmask;
  logic [31:0] io_rdata;

  modport master (
    output mem_addr, mem_rstrb, mem_wdata, mem_wmask,
    input  io_rdata
  );

  modport slave (
    input  mem_addr, mem_rstrb, mem_wdata, mem_wmask,
    output io_rdata
  );
endinterface

// File: rtl/uart_rx_io.sv
// Memory-mapped 8N1 UART receiver: deserialises rxd into a small FIFO that the CPU
// polls (status word) and pops (data word) through the IO page.
module uart_rx_io #(
  parameter int unsigned CLK_FREQ_HZ = 12000000,
  parameter int unsigned BAUD_RATE   = 115200,
  parameter int unsigned FIFO_DEPTH  = 4
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        rxd,
  uart_rx_io_if.slave bus
);

  localparam int unsigned DIV   = CLK_FREQ_HZ / BAUD_RATE;
  localparam int unsigned CNT_W = $clog2(DIV);
  localparam int unsigned AW    = $clog2(FIFO_DEPTH);
  localparam int unsigned PW    = AW + 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  logic             sync1_q, rx_s_q;
  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bitn_q, bitn_d;
  logic [7:0]       shift_q, shift_d;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic             ovr_q, ovr_d, ferr_q, ferr_d;
  logic [31:0]      rdata_q, rdata_d;
  logic [7:0]       fifo_q [FIFO_DEPTH];

  logic       push_c, ferr_set_c;
  logic       nonempty_c, full_c, pop_c, push_ok_c, ovr_set_c;
  logic       io_sel_c, rx_rd_c, st_rd_c, st_wr_c;
  logic [7:0] head_c;
  logic       unused_bus;

  assign unused_bus = ^{bus.mem_wdata, bus.mem_addr[31:23], bus.mem_addr[21:7],
                        bus.mem_addr[4:0]};

  // Receiver FSM: mid-bit sampling driven by a down-counter reloaded each bit.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bitn_d     = bitn_q;
    shift_d    = shift_q;
    push_c     = 1'b0;
    ferr_set_c = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!rx_s_q) begin
          cnt_d   = CNT_W'(DIV / 2 - 1);
          state_d = S_START;
        end
      end
      S_START: begin
        if (cnt_q == '0) begin
          if (rx_s_q) begin
            state_d = S_IDLE;
          end else begin
            cnt_d   = CNT_W'(DIV - 1);
            bitn_d  = 3'd0;
            state_d = S_DATA;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_DATA: begin
        if (cnt_q == '0) begin
          shift_d = {rx_s_q, shift_q[7:1]};
          cnt_d   = CNT_W'(DIV - 1);
          bitn_d  = bitn_q + 3'd1;
          if (bitn_q == 3'd7) state_d = S_STOP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_STOP: begin
        if (cnt_q == '0) begin
          push_c     = rx_s_q;
          ferr_set_c = ~rx_s_q;
          state_d    = S_IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign io_sel_c = bus.mem_addr[22];
  assign rx_rd_c  = io_sel_c & bus.mem_addr[5] & bus.mem_rstrb;
  assign st_rd_c  = io_sel_c & bus.mem_addr[6] & bus.mem_rstrb;
  assign st_wr_c  = io_sel_c & bus.mem_addr[6] & (|bus.mem_wmask);

  assign nonempty_c = (wr_ptr_q != rd_ptr_q);
  assign full_c     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign head_c     = nonempty_c ? fifo_q[rd_ptr_q[AW-1:0]] : 8'h00;
  assign pop_c      = rx_rd_c & nonempty_c;
  // A pop in the same cycle frees the slot, so a push at full only overruns without one.
  assign push_ok_c  = push_c & (~full_c | pop_c);
  assign ovr_set_c  = push_c & full_c & ~pop_c;

  // Pointers, sticky flags and the registered read-data word.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    ovr_d    = ovr_q;
    ferr_d   = ferr_q;
    rdata_d  = rdata_q;
    if (push_ok_c) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop_c)     rd_ptr_d = rd_ptr_q + PW'(1);
    if (st_wr_c) begin
      ovr_d  = 1'b0;
      ferr_d = 1'b0;
    end
    if (ovr_set_c)  ovr_d  = 1'b1;
    if (ferr_set_c) ferr_d = 1'b1;
    if (rx_rd_c) begin
      rdata_d = {23'b0, nonempty_c, head_c};
    end else if (st_rd_c) begin
      rdata_d = {28'b0, full_c, ferr_q, ovr_q, nonempty_c};
    end else if (bus.mem_rstrb) begin
      rdata_d = 32'b0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sync1_q  <= 1'b1;
      rx_s_q   <= 1'b1;
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      bitn_q   <= 3'd0;
      shift_q  <= 8'h00;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      ovr_q    <= 1'b0;
      ferr_q   <= 1'b0;
      rdata_q  <= 32'b0;
    end else begin
      sync1_q  <= rxd;
      rx_s_q   <= sync1_q;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bitn_q   <= bitn_d;
      shift_q  <= shift_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      ovr_q    <= ovr_d;
      ferr_q   <= ferr_d;
      rdata_q  <= rdata_d;
    end
  end

  // Storage needs no reset: the pointers define which entries are valid.
  always_ff @(posedge clk) begin
    if (push_ok_c) fifo_q[wr_ptr_q[AW-1:0]] <= shift_q;
  end

  assign bus.io_rdata = rdata_q;

endmodule

// File: tb/tb_uart_rx_io.sv
// Scoreboard bench for uart_rx_io: directed serial frames and CPU polls, checked by a monitor.
module tb_uart_rx_io;
  localparam int unsigned DIV = 8;
  localparam logic [31:0] A_RX   = 32'h0040_0020;
  localparam logic [31:0] A_STAT = 32'h0040_0040;

  logic clk = 1'b0;
  logic resetn;
  logic rxd;
  uart_rx_io_if bus ();

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_q[$];
  string       name_q[$];

  uart_rx_io #(.CLK_FREQ_HZ(800), .BAUD_RATE(100), .FIFO_DEPTH(4)) dut (
    .clk    (clk),
    .resetn (resetn),
    .rxd    (rxd),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%03h expected 0x%03h", nm, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic cpu_read(input logic [31:0] addr, input logic [31:0] exp, input string nm);
    @(negedge clk);
    bus.mem_addr  = addr;
    bus.mem_rstrb = 1'b1;
    exp_q.push_back(exp);
    name_q.push_back(nm);
    @(posedge clk);
    #1 bus.mem_rstrb = 1'b0;
  endtask

  task automatic cpu_write(input logic [31:0] addr);
    @(negedge clk);
    bus.mem_addr  = addr;
    bus.mem_wdata = 32'hDEAD_BEEF;
    bus.mem_wmask = 4'hF;
    @(posedge clk);
    #1 bus.mem_wmask = 4'h0;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop);
    @(negedge clk);
    rxd = 1'b0;
    for (int i = 0; i < 8; i++) begin
      repeat (DIV) @(negedge clk);
      rxd = d[i];
    end
    repeat (DIV) @(negedge clk);
    rxd = stop;
    repeat (DIV) @(negedge clk);
    rxd = 1'b1;
  endtask

  // Monitor: every strobed read presents its data one cycle later.
  initial begin
    forever begin
      @(posedge clk);
      if (bus.mem_rstrb === 1'b1) begin
        @(negedge clk);
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_read: got 0x%03h expected no read", bus.io_rdata);
        end else begin
          check(name_q.pop_front(), bus.io_rdata, exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    resetn        = 1'b0;
    rxd           = 1'b1;
    bus.mem_addr  = 32'h0;
    bus.mem_rstrb = 1'b0;
    bus.mem_wdata = 32'h0;
    bus.mem_wmask = 4'h0;
    idle(3);
    check("reset_rdata", bus.io_rdata, 32'h0);
    resetn = 1'b1;
    idle(4);

    // Single byte
    send_frame(8'h61, 1'b1);
    idle(2 * DIV);
    cpu_read(A_STAT, 32'h1,   "single_stat");
    cpu_read(A_RX,   32'h161, "single_data");
    cpu_read(A_RX,   32'h000, "single_empty");
    cpu_read(A_STAT, 32'h0,   "single_stat_after");

    // Glitch rejection
    @(negedge clk);
    rxd = 1'b0;
    idle(2);
    rxd = 1'b1;
    idle(3 * DIV);
    cpu_read(A_STAT, 32'h0, "glitch_stat");

    // Framing error
    send_frame(8'h55, 1'b0);
    idle(2 * DIV);
    cpu_read(A_STAT, 32'h4, "ferr_stat");
    cpu_write(A_STAT);
    cpu_read(A_STAT, 32'h0, "ferr_cleared");

    // Overrun and full
    for (int i = 0; i < 5; i++) send_frame(8'(8'h30 + i), 1'b1);
    idle(2 * DIV);
    cpu_read(A_STAT, 32'hB, "ovr_stat");
    for (int i = 0; i < 4; i++) cpu_read(A_RX, 32'h130 + 32'(i), "ovr_data");
    cpu_read(A_RX, 32'h000, "ovr_empty");
    cpu_write(A_STAT);

    // Push and pop in the same cycle while full
    for (int i = 0; i < 4; i++) send_frame(8'(8'h40 + i), 1'b1);
    idle(2 * DIV);
    fork
      send_frame(8'h44, 1'b1);
      begin
        @(negedge clk);
        repeat (78) @(posedge clk);
        cpu_read(A_RX, 32'h140, "simul_pop");
      end
    join
    idle(2 * DIV);
    cpu_read(A_STAT, 32'h9, "simul_stat");
    for (int i = 1; i < 5; i++) cpu_read(A_RX, 32'h140 + 32'(i), "simul_data");
    cpu_read(A_RX, 32'h000, "simul_empty");

    // Reset mid-frame, with a byte already queued
    send_frame(8'h5A, 1'b1);
    idle(2 * DIV);
    cpu_read(A_STAT, 32'h1, "prereset_stat");
    @(negedge clk);
    rxd = 1'b0;
    idle(5 * DIV + 4);
    resetn = 1'b0;
    rxd    = 1'b1;
    idle(3);
    check("midreset_rdata", bus.io_rdata, 32'h0);
    resetn = 1'b1;
    idle(2 * DIV);
    cpu_read(A_STAT, 32'h0, "postreset_stat");
    send_frame(8'hA5, 1'b1);
    idle(2 * DIV);
    cpu_read(A_RX, 32'h1A5, "postreset_data");

    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
    if (exp_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain: got %0d pending reads expected 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
